scope_uart_framer: RTL and testbench
====================================

# scope_uart_framer

Packetizer directly upstream of `uart_tx`: accepts acquired ADC samples, buffers them in a small FIFO, and emits framed byte streams (sync, sequence, samples, optional checksum) one byte at a time using the `uart_tx` data-valid/done handshake. It sits between the acquisition/trigger logic and the UART link to the host.

## Interface
- `SAMPLE_WIDTH`, 12, sample bits; legal range 9..16.
- `FIFO_DEPTH`, 16, sample FIFO entries; power of two, ≥ `SAMPLES_PER_FRAME`.
- `SAMPLES_PER_FRAME`, 8, samples per frame; 1..255.
- `i_clk`  in  1  system clock.
- `i_rst`  in  1  reset, synchronous, active-high.
- `i_sample`  in  SAMPLE_WIDTH  sample data.
- `i_sample_valid`  in  1  push `i_sample` this cycle.
- `i_tx_done`  in  1  one-cycle pulse from `uart_tx`: stop bit finished.
- `o_tx_data`  out  8  byte to `uart_tx`.
- `o_tx_data_valid`  out  1  one-cycle pulse: `o_tx_data` valid, start transmit.
- `o_busy`  out  1  high whenever a frame is in progress.
- `o_overflow`  out  1  sticky: a sample was dropped.

## Operation
- Frame byte order: `0xA5` sync, sequence byte, per sample high byte (`sample[SAMPLE_WIDTH-1:8]` zero-padded) then low byte (`sample[7:0]`), then checksum if enabled.
- FSM states: IDLE, SYNC, SEQ, HI, LO, CSUM.
- IDLE → SYNC when FIFO count ≥ `SAMPLES_PER_FRAME`; a frame never starts short, never stalls on FIFO empty.
- Every byte state: first cycle drives `o_tx_data` and pulses `o_tx_data_valid`; then waits for `i_tx_done`; advances the cycle after `i_tx_done`.
- `i_tx_done` in the valid-pulse cycle or in IDLE is ignored.
- SYNC → SEQ → HI → LO; LO → HI while samples sent < `SAMPLES_PER_FRAME`, else → CSUM (macro defined) or IDLE.
- FIFO pop in the HI valid cycle; popped sample held in a register for LO.
- Sequence counter: 8-bit, reset 0x00, increments on frame completion, wraps 0xFF → 0x00.
- Checksum: mod-256 sum of sequence byte and all sample bytes; sync excluded.
- FIFO push with `i_sample_valid` when not full. Full and no pop same cycle: sample dropped, `o_overflow` set. Full with pop same cycle: push accepted.
- `o_overflow` clears only on reset.

## Timing
- Reset values: `o_tx_data` 0x00, `o_tx_data_valid` 0, `o_busy` 0, `o_overflow` 0; FIFO empty, sequence 0, FSM IDLE.
- Push of the Nth sample at edge t makes count = N; `o_tx_data_valid` for sync is high in cycle t+1.
- `o_tx_data` stable from the valid pulse until the next byte's valid pulse.
- Byte spacing: valid pulses are exactly one cycle after the preceding `i_tx_done`.
- `o_busy` high from the sync valid cycle through the cycle of the final `i_tx_done`.
- Reset mid-frame: next cycle IDLE, FIFO flushed, no further valid pulses; a byte already in `uart_tx` completes, and its `i_tx_done` is ignored.

## Configuration
- `SCOPE_FRAMER_CHECKSUM_EN` defined: CSUM state present; frame = 2 + 2·N + 1 bytes.
- Undefined: no CSUM state, no accumulator logic; LO → IDLE after last sample; frame = 2 + 2·N bytes.

## Structure
- Package `scope_uart_pkg`: `SYNC_BYTE = 8'hA5`, FSM state encoding, sequence width constant; shared with the future host-command parser.
- Sub-module `sample_fifo`: synchronous single-clock FIFO, parameterised width/depth, push/pop/full/empty/count ports; framer owns the FSM, sequence counter, and checksum.

## Test plan
- N=2, checksum on; push 0x123, 0x0AB; ack each byte with `i_tx_done` 4 cycles after valid → bytes A5,00,01,23,00,AB,CF; `o_busy` falls after final done.
- Same stimulus, macro undefined → A5,00,01,23,00,AB, then IDLE; the second frame's sequence byte is 01.
- N=2, depth 4, `i_tx_done` held low; push 5 samples → stalled in SYNC, 5th dropped, `o_overflow`=1 and stays 1 after later frames.
- Push 1 sample with N=2 → no valid pulse; 2nd push → sync valid exactly one cycle later.
- Run 257 frames → sequence bytes 00..FF, then 00.
- Assert `i_rst` during a LO byte wait, then pulse `i_tx_done` → no valid pulse, outputs at reset values, FIFO empty, next frame's sequence byte 00.

Source files
------------

// File: rtl/scope_uart_pkg.sv
// Shared framing constants and FSM encoding for the scope UART link.
// SCOPE_FRAMER_CHECKSUM_EN adds the CSUM state to the encoding.
package scope_uart_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam int         SEQ_WIDTH = 8;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SYNC = 3'd1,
    ST_SEQ  = 3'd2,
    ST_HI   = 3'd3,
    ST_LO   = 3'd4
`ifdef SCOPE_FRAMER_CHECKSUM_EN
    , ST_CSUM = 3'd5
`endif
  } frame_state_e;

endpackage

// File: rtl/sample_fifo.sv
// Single-clock sample FIFO with occupancy count; a push into a full FIFO
// is accepted only when a pop frees a slot in the same cycle.
module sample_fifo #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wr_data,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/scope_uart_framer.sv
// Frames buffered ADC samples into sync/seq/sample byte streams for uart_tx.
// Define SCOPE_FRAMER_CHECKSUM_EN to append a mod-256 checksum byte.
module scope_uart_framer
  import scope_uart_pkg::*;
#(
  parameter int SAMPLE_WIDTH      = 12,
  parameter int FIFO_DEPTH        = 16,
  parameter int SAMPLES_PER_FRAME = 8
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [SAMPLE_WIDTH-1:0] i_sample,
  input  logic                    i_sample_valid,
  input  logic                    i_tx_done,
  output logic [7:0]              o_tx_data,
  output logic                    o_tx_data_valid,
  output logic                    o_busy,
  output logic                    o_overflow
);

  localparam int                CW        = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0]     FRAME_CNT = CW'(SAMPLES_PER_FRAME);
  localparam logic [7:0]        FRAME_N8  = 8'(SAMPLES_PER_FRAME);

  frame_state_e          state_q, state_d;
  logic                  sent_q;
  logic                  byte_done;
  logic                  last_sample;
  logic                  frame_done;
  logic                  fifo_pop;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [CW-1:0]         fifo_count;
  logic [SAMPLE_WIDTH-1:0] fifo_head;
  logic [7:0]            hi_byte;
  logic [7:0]            lo_q;
  logic [7:0]            byte_d;
  logic [7:0]            tx_data_q;
  logic [SEQ_WIDTH-1:0]  seq_q;
  logic [7:0]            sent_cnt_q;
`ifdef SCOPE_FRAMER_CHECKSUM_EN
  logic [7:0]            csum_q;
`endif

  sample_fifo #(
    .WIDTH (SAMPLE_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (i_clk),
    .rst     (i_rst),
    .push    (i_sample_valid),
    .pop     (fifo_pop),
    .wr_data (i_sample),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign hi_byte     = 8'(fifo_head[SAMPLE_WIDTH-1:8]);
  assign byte_done   = sent_q && i_tx_done;
  assign last_sample = (sent_cnt_q == FRAME_N8);
  assign frame_done  = byte_done && (state_d == ST_IDLE);
  assign fifo_pop    = o_tx_data_valid && (state_q == ST_HI) && !fifo_empty;

  // sent_q marks that this state's byte has been handed to uart_tx
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      sent_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sent_q  <= (state_q != ST_IDLE) && (state_d == state_q);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (fifo_count >= FRAME_CNT) state_d = ST_SYNC;
      ST_SYNC: if (byte_done) state_d = ST_SEQ;
      ST_SEQ:  if (byte_done) state_d = ST_HI;
      ST_HI:   if (byte_done) state_d = ST_LO;
      ST_LO: begin
        if (byte_done) begin
          if (!last_sample) state_d = ST_HI;
`ifdef SCOPE_FRAMER_CHECKSUM_EN
          else              state_d = ST_CSUM;
`else
          else              state_d = ST_IDLE;
`endif
        end
      end
`ifdef SCOPE_FRAMER_CHECKSUM_EN
      ST_CSUM: if (byte_done) state_d = ST_IDLE;
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    o_tx_data_valid = (state_q != ST_IDLE) && !sent_q;
    o_busy          = (state_q != ST_IDLE);
    byte_d          = tx_data_q;
    case (state_q)
      ST_SYNC: byte_d = SYNC_BYTE;
      ST_SEQ:  byte_d = seq_q;
      ST_HI:   byte_d = hi_byte;
      ST_LO:   byte_d = lo_q;
`ifdef SCOPE_FRAMER_CHECKSUM_EN
      ST_CSUM: byte_d = csum_q;
`endif
      default: byte_d = tx_data_q;
    endcase
    o_tx_data = o_tx_data_valid ? byte_d : tx_data_q;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      tx_data_q  <= 8'h00;
      lo_q       <= 8'h00;
      seq_q      <= '0;
      sent_cnt_q <= 8'h00;
      o_overflow <= 1'b0;
    end else begin
      if (o_tx_data_valid) tx_data_q <= byte_d;
      if (state_q == ST_SYNC) sent_cnt_q <= 8'h00;
      if (fifo_pop) begin
        lo_q       <= fifo_head[7:0];
        sent_cnt_q <= sent_cnt_q + 8'd1;
      end
      if (i_sample_valid && fifo_full && !fifo_pop) o_overflow <= 1'b1;
      if (frame_done) seq_q <= seq_q + SEQ_WIDTH'(1);
    end
  end

`ifdef SCOPE_FRAMER_CHECKSUM_EN
  // sync byte is excluded from the running sum
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      csum_q <= 8'h00;
    end else if (state_q == ST_SYNC) begin
      csum_q <= 8'h00;
    end else if (o_tx_data_valid && (state_q != ST_CSUM)) begin
      csum_q <= csum_q + byte_d;
    end
  end
`endif

endmodule

// File: tb/tb_scope_uart_framer.sv
// Scoreboard bench for scope_uart_framer (N=2, depth 4, 12-bit samples).
module tb_scope_uart_framer;

  localparam int SW    = 12;
  localparam int DEPTH = 4;
  localparam int N     = 2;

  logic          i_clk = 1'b0;
  logic          i_rst;
  logic [SW-1:0] i_sample;
  logic          i_sample_valid;
  logic          i_tx_done;
  logic [7:0]    o_tx_data;
  logic          o_tx_data_valid;
  logic          o_busy;
  logic          o_overflow;

  scope_uart_framer #(
    .SAMPLE_WIDTH      (SW),
    .FIFO_DEPTH        (DEPTH),
    .SAMPLES_PER_FRAME (N)
  ) dut (
    .i_clk           (i_clk),
    .i_rst           (i_rst),
    .i_sample        (i_sample),
    .i_sample_valid  (i_sample_valid),
    .i_tx_done       (i_tx_done),
    .o_tx_data       (o_tx_data),
    .o_tx_data_valid (o_tx_data_valid),
    .o_busy          (o_busy),
    .o_overflow      (o_overflow)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [7:0] data;
    bit         first;
  } exp_t;

  exp_t       exp_q[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         vcount = 0;
  int         last_done_cyc = 0;
  int         delay = 0;
  bit         tx_en = 1'b1;
  bit         pending = 1'b0;
  bit         stray_done = 1'b0;
  logic [7:0] last_data = 8'h00;
  logic [7:0] model_seq = 8'h00;

  always @(posedge i_clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_byte(input logic [7:0] d, input bit first);
    exp_t e;
    e.data  = d;
    e.first = first;
    exp_q.push_back(e);
  endtask

  task automatic expect_frame(input logic [SW-1:0] s0, input logic [SW-1:0] s1);
    logic [7:0] h0, h1, sum;
    h0  = {4'h0, s0[11:8]};
    h1  = {4'h0, s1[11:8]};
    sum = model_seq + h0 + s0[7:0] + h1 + s1[7:0];
    expect_byte(8'hA5, 1'b1);
    expect_byte(model_seq, 1'b0);
    expect_byte(h0, 1'b0);
    expect_byte(s0[7:0], 1'b0);
    expect_byte(h1, 1'b0);
    expect_byte(s1[7:0], 1'b0);
`ifdef SCOPE_FRAMER_CHECKSUM_EN
    expect_byte(sum, 1'b0);
`endif
    model_seq = model_seq + 8'd1;
  endtask

  task automatic push_sample(input logic [SW-1:0] s);
    @(negedge i_clk);
    i_sample       = s;
    i_sample_valid = 1'b1;
    @(negedge i_clk);
    i_sample_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || pending) && n < 3000) begin
      @(negedge i_clk);
      n++;
    end
    check({name, "_drained"}, exp_q.size(), 0);
    repeat (2) @(negedge i_clk);
    check({name, "_busy_low"}, o_busy, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge i_clk);
    i_rst = 1'b1;
    repeat (2) @(negedge i_clk);
    i_rst = 1'b0;
    exp_q.delete();
    model_seq = 8'h00;
  endtask

  // uart_tx stand-in: acknowledges each byte 4 cycles after its valid pulse
  initial begin
    i_tx_done = 1'b0;
    forever begin
      @(negedge i_clk);
      i_tx_done = 1'b0;
      if (o_tx_data_valid) begin
        pending = 1'b1;
        delay   = 0;
      end else if (pending && tx_en) begin
        delay++;
        if (delay >= 4) begin
          i_tx_done     = 1'b1;
          pending       = 1'b0;
          last_done_cyc = cyc;
          if (stray_done) stray_done = 1'b0;
          else            check("busy_at_done", o_busy, 1'b1);
        end
      end
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge i_clk);
      if (o_tx_data_valid) begin
        vcount++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_valid: got byte %0h expected no byte", o_tx_data);
        end else begin
          e = exp_q.pop_front();
          check("tx_byte", o_tx_data, e.data);
          check("busy_on_valid", o_busy, 1'b1);
          if (!e.first) check("byte_spacing", cyc - last_done_cyc, 1);
        end
        last_data = o_tx_data;
      end else if (o_busy) begin
        check("data_stable", o_tx_data, last_data);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    int n;
    i_rst          = 1'b1;
    i_sample       = '0;
    i_sample_valid = 1'b0;
    repeat (3) @(negedge i_clk);
    i_rst = 1'b0;
    @(negedge i_clk);
    check("rst_tx_data", o_tx_data, 8'h00);
    check("rst_valid", o_tx_data_valid, 1'b0);
    check("rst_busy", o_busy, 1'b0);
    check("rst_overflow", o_overflow, 1'b0);

    // one sample short of a frame: nothing goes out
    base = vcount;
    push_sample(12'h123);
    repeat (6) @(negedge i_clk);
    check("no_short_frame", vcount - base, 0);
    expect_byte(8'hA5, 1'b1);
    expect_byte(8'h00, 1'b0);
    expect_byte(8'h01, 1'b0);
    expect_byte(8'h23, 1'b0);
    expect_byte(8'h00, 1'b0);
    expect_byte(8'hAB, 1'b0);
`ifdef SCOPE_FRAMER_CHECKSUM_EN
    expect_byte(8'hCF, 1'b0);
`endif
    model_seq = 8'h01;
    push_sample(12'h0AB);
    check("sync_not_early", o_tx_data_valid, 1'b0);
    @(negedge i_clk);
    check("sync_latency", o_tx_data_valid, 1'b1);
    wait_drain("frame0");

    expect_byte(8'hA5, 1'b1);
    expect_byte(8'h01, 1'b0);
    expect_byte(8'h07, 1'b0);
    expect_byte(8'hFF, 1'b0);
    expect_byte(8'h08, 1'b0);
    expect_byte(8'h00, 1'b0);
`ifdef SCOPE_FRAMER_CHECKSUM_EN
    expect_byte(8'h0F, 1'b0);
`endif
    model_seq = 8'h02;
    push_sample(12'h7FF);
    push_sample(12'h800);
    wait_drain("frame1");

    // overflow: uart stalled in SYNC, FIFO fills, fifth sample dropped
    tx_en = 1'b0;
    base  = vcount;
    expect_frame(12'h111, 12'h222);
    expect_frame(12'h333, 12'h444);
    push_sample(12'h111);
    push_sample(12'h222);
    push_sample(12'h333);
    push_sample(12'h444);
    check("no_overflow_at_full", o_overflow, 1'b0);
    push_sample(12'h555);
    repeat (2) @(negedge i_clk);
    check("overflow_set", o_overflow, 1'b1);
    check("stalled_busy", o_busy, 1'b1);
    check("stalled_one_valid", vcount - base, 1);
    tx_en = 1'b1;
    wait_drain("overflow_frames");
    check("overflow_sticky", o_overflow, 1'b1);

    // reset during the LO byte wait, with one sample still buffered
    base = vcount;
    expect_frame(12'h9AB, 12'hCDE);
    push_sample(12'h9AB);
    push_sample(12'hCDE);
    push_sample(12'h0F0);
    n = 0;
    while (vcount - base < 4 && n < 200) begin
      @(negedge i_clk);
      n++;
    end
    check("reached_lo", vcount - base, 4);
    @(negedge i_clk);
    stray_done = 1'b1;
    i_rst      = 1'b1;
    @(negedge i_clk);
    i_rst = 1'b0;
    exp_q.delete();
    model_seq = 8'h00;
    check("midrst_tx_data", o_tx_data, 8'h00);
    check("midrst_valid", o_tx_data_valid, 1'b0);
    check("midrst_busy", o_busy, 1'b0);
    check("midrst_overflow", o_overflow, 1'b0);
    base = vcount;
    repeat (10) @(negedge i_clk);
    check("midrst_no_valid", vcount - base, 0);
    push_sample(12'h321);
    repeat (8) @(negedge i_clk);
    check("midrst_fifo_flushed", vcount - base, 0);
    expect_frame(12'h321, 12'h654);
    push_sample(12'h654);
    wait_drain("post_reset_frame");

    // 257 frames from reset: sequence runs 00..FF and wraps to 00
    do_reset();
    for (int i = 0; i < 257; i++) begin
      expect_frame(12'(i * 37), 12'(12'hFFF - i * 11));
      push_sample(12'(i * 37));
      push_sample(12'(12'hFFF - i * 11));
      wait_drain("seq_run");
    end
    check("seq_wrapped", model_seq, 8'h01);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
